// File: rtl/alu24_muldiv_seq.sv
// Iterative unsigned multiply/divide sequencer that borrows the shared ripple ALU
// for its add/subtract steps: shift-add multiply and restoring divide, 24 steps each.
module alu24_muldiv_seq #(
  parameter int         WIDTH  = 24,
  parameter logic [1:0] ADD_OP = 2'b10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  output logic             alu_bnegate,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carryout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic             r_op;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_hi;      // HI (multiply) / R (divide)
  logic [WIDTH-1:0] r_lo;      // LO (multiply) / Q (divide)
  logic [WIDTH-1:0] r_m;       // M (multiply) / D (divide)
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_res_hi;
  logic [WIDTH-1:0] r_res_lo;
  logic             r_dbz;

  logic             w_t_top;
  logic [WIDTH-1:0] w_t_low;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;

  // Divide trial value T = {R, Q[msb]}; its top bit never reaches the ALU.
  assign w_t_top = r_hi[WIDTH-1];
  assign w_t_low = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};

  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_op      = ADD_OP;
    alu_bnegate = 1'b0;
    if (r_state == RUN) begin
      if (r_op) begin
        alu_a       = w_t_low;
        alu_b       = r_m;
        alu_bnegate = 1'b1;
      end else begin
        alu_a = r_hi;
        alu_b = r_m;
      end
    end
  end

  always_comb begin
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (r_op) begin
      // Subtraction fits when T >= D: either T overflowed 24 bits or no borrow.
      if (w_t_top | alu_carryout) begin
        w_hi_nxt = alu_result;
        w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_hi_nxt = w_t_low;
        w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
      end
    end else if (r_lo[0]) begin
      w_hi_nxt = {alu_carryout, alu_result[WIDTH-1:1]};
      w_lo_nxt = {alu_result[0], r_lo[WIDTH-1:1]};
    end else begin
      w_hi_nxt = {1'b0, r_hi[WIDTH-1:1]};
      w_lo_nxt = {r_hi[0], r_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_op     <= 1'b0;
      r_count  <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_m      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_res_hi <= '0;
      r_res_lo <= '0;
      r_dbz    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_op    <= op;
            r_count <= '0;
            r_dbz   <= 1'b0;
            r_hi    <= '0;
            if (op && (opb == '0)) begin
              r_state  <= DONE;
              r_done   <= 1'b1;
              r_res_hi <= opa;
              r_res_lo <= '1;
              r_dbz    <= 1'b1;
              r_lo     <= opa;
              r_m      <= '0;
            end else begin
              r_state <= RUN;
              r_busy  <= 1'b1;
              r_lo    <= op ? opa : opb;
              r_m     <= op ? opb : opa;
            end
          end
        end
        RUN: begin
          r_hi    <= w_hi_nxt;
          r_lo    <= w_lo_nxt;
          r_count <= r_count + CNT_W'(1);
          if (r_count == LAST) begin
            r_state  <= DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_res_hi <= w_hi_nxt;
            r_res_lo <= w_lo_nxt;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign result_hi   = r_res_hi;
  assign result_lo   = r_res_lo;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_alu24_muldiv_seq.sv
// Bench for alu24_muldiv_seq: a behavioural ALU on the ALU port, an arithmetic
// reference model compared every cycle, and directed literal checks.
module tb_alu24_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [23:0] opa = '0;
  logic [23:0] opb = '0;
  logic        busy, done, div_by_zero;
  logic [23:0] result_hi, result_lo;
  logic [23:0] alu_a, alu_b, alu_result;
  logic [1:0]  alu_op;
  logic        alu_bnegate, alu_carryout;

  int n_checks = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  alu24_muldiv_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .result_hi(result_hi), .result_lo(result_lo),
    .div_by_zero(div_by_zero), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_bnegate(alu_bnegate), .alu_result(alu_result), .alu_carryout(alu_carryout)
  );

  // Ripple ALU stand-in: add, or subtract via inverted B with carry-in.
  logic [24:0] w_sum;
  always_comb begin
    if (alu_op == 2'b10)
      w_sum = {1'b0, alu_a} + {1'b0, (alu_bnegate ? ~alu_b : alu_b)} + {24'd0, alu_bnegate};
    else
      w_sum = {1'b0, alu_a & alu_b};
  end
  assign alu_result   = w_sum[23:0];
  assign alu_carryout = w_sum[24];

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycles remaining, results from plain arithmetic.
  int          m_cnt;
  logic        m_busy, m_done, m_dz, m_op;
  logic [23:0] m_hi, m_lo, p_hi, p_lo;
  logic [47:0] prod;
  always_comb prod = {24'd0, opa} * {24'd0, opb};

  always @(posedge clk) begin
    if (reset) begin
      m_cnt <= 0; m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
      m_hi <= '0; m_lo <= '0; m_op <= 1'b0;
    end else if (m_cnt > 1) begin
      m_cnt <= m_cnt - 1;
    end else if (m_cnt == 1) begin
      m_cnt <= 0; m_busy <= 1'b0; m_done <= 1'b1;
      m_hi <= p_hi; m_lo <= p_lo;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (start) begin
      m_op <= op;
      m_dz <= 1'b0;
      if (op && opb == 0) begin
        m_done <= 1'b1; m_dz <= 1'b1; m_hi <= opa; m_lo <= 24'hFFFFFF;
      end else begin
        m_cnt <= 24; m_busy <= 1'b1;
        p_hi <= op ? (opa % opb) : prod[47:24];
        p_lo <= op ? (opa / opb) : prod[23:0];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {47'd0, busy}, {47'd0, m_busy});
      chk("done", {47'd0, done}, {47'd0, m_done});
      chk("result_hi", {24'd0, result_hi}, {24'd0, m_hi});
      chk("result_lo", {24'd0, result_lo}, {24'd0, m_lo});
      chk("div_by_zero", {47'd0, div_by_zero}, {47'd0, m_dz});
      chk("alu_op", {46'd0, alu_op}, 48'd2);
      chk("alu_bnegate", {47'd0, alu_bnegate}, {47'd0, m_busy & m_op});
      if (!m_busy) chk("alu_idle_ab", {alu_a, alu_b}, 48'd0);
    end
  end

  task automatic go(input logic o, input logic [23:0] a, input logic [23:0] b);
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk("done_seen", {47'd0, done}, 48'd1);
  endtask

  initial begin
    int lat;
    logic       ro;
    logic [23:0] ra, rb;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_busy", {47'd0, busy}, 48'd0);
    chk("rst_res", {result_hi, result_lo}, 48'd0);

    go(1'b0, 24'd3, 24'd5);
    wait_done(lat);
    chk("mul3x5_lat", 48'(lat), 48'd25);
    chk("mul3x5", {result_hi, result_lo}, 48'd15);

    go(1'b0, 24'hFFFFFF, 24'hFFFFFF);
    wait_done(lat);
    chk("mulmax", {result_hi, result_lo}, 48'hFFFFFE_000001);
    chk("mulmax_dz", {47'd0, div_by_zero}, 48'd0);

    go(1'b1, 24'd100, 24'd7);
    wait_done(lat);
    chk("div100_7_lat", 48'(lat), 48'd25);
    chk("div100_7", {result_hi, result_lo}, {24'd2, 24'd14});

    go(1'b1, 24'hFFFFFF, 24'd1);
    wait_done(lat);
    chk("divmax_1", {result_hi, result_lo}, {24'd0, 24'hFFFFFF});

    go(1'b1, 24'd1234, 24'd0);
    wait_done(lat);
    chk("div0_lat", 48'(lat), 48'd1);
    chk("div0", {result_hi, result_lo}, {24'd1234, 24'hFFFFFF});
    chk("div0_flag", {47'd0, div_by_zero}, 48'd1);

    go(1'b0, 24'd6, 24'd7);
    start = 1'b1; op = 1'b1; opa = 24'd9; opb = 24'd4;
    wait_done(lat);
    chk("ignore_lat", 48'(lat), 48'd25);
    @(negedge clk);
    start = 1'b0;
    chk("ignore_res", {result_hi, result_lo}, 48'd42);
    go(1'b1, 24'd9, 24'd4);
    wait_done(lat);
    chk("after_ignore", {result_hi, result_lo}, {24'd1, 24'd2});

    go(1'b0, 24'd11, 24'd13);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_ctl", {46'd0, busy, done}, 48'd0);
    chk("midrst_res", {result_hi, result_lo}, 48'd0);
    chk("midrst_dz", {47'd0, div_by_zero}, 48'd0);
    repeat (20) @(negedge clk);

    for (int i = 0; i < 1000; i++) begin
      ro = 1'($urandom_range(0, 1));
      ra = 24'($urandom) >> $urandom_range(0, 23);
      rb = 24'($urandom) >> $urandom_range(0, 23);
      if ($urandom_range(0, 15) == 0) rb = '0;
      go(ro, ra, rb);
      wait_done(lat);
      chk("rand_lat", 48'(lat), (ro && rb == 0) ? 48'd1 : 48'd25);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
